// File: rtl/pipeline_stall_controller.sv
// Central freeze/flush sequencer for the 5-stage pipeline: merges MEM-stage SRAM
// stalls, EXE branch flushes and ID hazard bubbles, plus debug counters.
module pipeline_stall_controller #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_Detected,
  input  logic             B_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             sram_go,
  output logic             pc_freeze,
  output logic             if_id_freeze,
  output logic             if_id_flush,
  output logic             id_exe_flush,
  output logic             global_freeze,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WC_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              to_hit_s;
  logic              mem_stall_s;

  // Stall decode and same-cycle freeze/flush priority: memory > branch > hazard.
  always_comb begin
    to_hit_s      = (state_q == MEM_WAIT) && (wait_cnt_q == WC_W'(TIMEOUT - 1));
    mem_stall_s   = ((state_q == RUN) && mem_req) ||
                    ((state_q == MEM_WAIT) && !mem_ready && !to_hit_s);
    sram_go       = ((state_q == RUN) && mem_req) || (state_q == MEM_WAIT);
    pc_freeze     = 1'b0;
    if_id_freeze  = 1'b0;
    if_id_flush   = 1'b0;
    id_exe_flush  = 1'b0;
    global_freeze = 1'b0;
    if (mem_stall_s) begin
      pc_freeze     = 1'b1;
      if_id_freeze  = 1'b1;
      global_freeze = 1'b1;
    end else if (B_taken) begin
      if_id_flush  = 1'b1;
      id_exe_flush = 1'b1;
    end else if (hazard_Detected) begin
      pc_freeze    = 1'b1;
      if_id_freeze = 1'b1;
      id_exe_flush = 1'b1;
    end else begin
      pc_freeze = 1'b0;
    end
  end

  // Next-state for the access FSM, sticky timeout and saturating counters.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = timeout_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      RUN: begin
        if (mem_req) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end else begin
          state_d = RUN;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_d = RUN;
        end else if (to_hit_s) begin
          state_d   = RUN;
          timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WC_W'(1);
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
    if (pc_freeze && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (B_taken && !mem_stall_s && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // State and counter registers; reset drops an in-flight access immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_timeout = timeout_q;
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench for pipeline_stall_controller: directed scenarios plus
// randomized traffic against a cycle-level behavioural model.
module tb_pipeline_stall_controller;

  localparam int TO   = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          hazard_Detected = 1'b0, B_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
  logic          sram_go, pc_freeze, if_id_freeze, if_id_flush, id_exe_flush, global_freeze;
  logic          mem_timeout;
  logic [CW-1:0] stall_count, flush_count;

  pipeline_stall_controller #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .hazard_Detected(hazard_Detected), .B_taken(B_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .sram_go(sram_go), .pc_freeze(pc_freeze),
    .if_id_freeze(if_id_freeze), .if_id_flush(if_id_flush), .id_exe_flush(id_exe_flush),
    .global_freeze(global_freeze), .mem_timeout(mem_timeout),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ctl bit order: {sram_go, pc_freeze, if_id_freeze, if_id_flush, id_exe_flush, global_freeze}
  wire [5:0] ctl = {sram_go, pc_freeze, if_id_freeze, if_id_flush, id_exe_flush, global_freeze};

  // Behavioural model: access outstanding flag, cycles waited, sticky flag, counts.
  bit       m_busy;
  int       m_waited;
  bit       m_to;
  int       m_sc, m_fc;
  bit       e_stall;
  logic [5:0] e_ctl;

  function automatic void model_reset();
    m_busy = 1'b0; m_waited = 0; m_to = 1'b0; m_sc = 0; m_fc = 0;
  endfunction

  function automatic void model_eval();
    if (!m_busy) e_stall = mem_req;
    else         e_stall = !(mem_ready || (m_waited == TO - 1));
    e_ctl    = 6'd0;
    e_ctl[5] = m_busy || mem_req;
    if (e_stall)              e_ctl[4:0] = 5'b11001;
    else if (B_taken)         e_ctl[4:0] = 5'b00110;
    else if (hazard_Detected) e_ctl[4:0] = 5'b11010;
  endfunction

  function automatic void model_edge();
    if (e_ctl[4] && m_sc < CMAX) m_sc++;
    if (B_taken && !e_stall && m_fc < CMAX) m_fc++;
    if (!m_busy) begin
      if (mem_req) begin m_busy = 1'b1; m_waited = 0; end
    end else if (mem_ready) begin
      m_busy = 1'b0;
    end else if (m_waited == TO - 1) begin
      m_busy = 1'b0; m_to = 1'b1;
    end else begin
      m_waited++;
    end
  endfunction

  task automatic drive(input logic h, input logic b, input logic q, input logic r);
    hazard_Detected = h; B_taken = b; mem_req = q; mem_ready = r;
    #1;
    model_eval();
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      total++;
      if (ctl !== 6'd0 || mem_timeout !== 1'b0 || stall_count !== '0 || flush_count !== '0) begin
        bad++;
        $display("FAIL reset_idle c=%0d: ctl=%b to=%b sc=%0d fc=%0d, want all 0", c, ctl, mem_timeout, stall_count, flush_count);
      end
      tick();
    end
  endtask

  task automatic test_hazard();
    do_reset();
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      total++;
      if (ctl !== 6'b011010) begin
        bad++; $display("FAIL hazard_ctl c=%0d: ctl=%b want 011010", c, ctl);
      end
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (stall_count !== CW'(2) || ctl !== 6'd0) begin
      bad++; $display("FAIL hazard_count: sc=%0d ctl=%b want sc=2 ctl=000000", stall_count, ctl);
    end
  endtask

  task automatic test_mem_access();
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      drive(1'b0, 1'b0, 1'b1, (c == 4));
      total++;
      if (ctl !== ((c < 4) ? 6'b111001 : 6'b100000)) begin
        bad++; $display("FAIL mem_ctl c=%0d: ctl=%b want %b", c, ctl, (c < 4) ? 6'b111001 : 6'b100000);
      end
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (ctl !== 6'd0 || stall_count !== CW'(3)) begin
      bad++; $display("FAIL mem_release: ctl=%b sc=%0d want ctl=000000 sc=3", ctl, stall_count);
    end
  endtask

  task automatic test_branch_in_wait();
    do_reset();
    for (int c = 1; c <= 2; c++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      total++;
      if (ctl !== 6'b111001) begin
        bad++; $display("FAIL wait_branch c=%0d: ctl=%b want 111001", c, ctl);
      end
      tick();
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    total++;
    if (ctl !== 6'b100110 || flush_count !== '0) begin
      bad++; $display("FAIL release_branch: ctl=%b fc=%0d want ctl=100110 fc=0", ctl, flush_count);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (flush_count !== CW'(1) || ctl !== 6'd0) begin
      bad++; $display("FAIL release_fcount: fc=%0d ctl=%b want fc=1 ctl=000000", flush_count, ctl);
    end
  endtask

  task automatic test_branch_hazard();
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    total++;
    if (ctl !== 6'b000110) begin
      bad++; $display("FAIL branch_over_hazard: ctl=%b want 000110", ctl);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (flush_count !== CW'(1) || stall_count !== '0) begin
      bad++; $display("FAIL branch_counts: fc=%0d sc=%0d want fc=1 sc=0", flush_count, stall_count);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int c = 1; c <= 5; c++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      total++;
      if (ctl !== ((c < 5) ? 6'b111001 : 6'b100000) || mem_timeout !== 1'b0) begin
        bad++; $display("FAIL timeout_seq c=%0d: ctl=%b to=%b want %b to=0", c, ctl, mem_timeout, (c < 5) ? 6'b111001 : 6'b100000);
      end
      tick();
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    total++;
    if (mem_timeout !== 1'b1 || stall_count !== CW'(4) || ctl !== 6'b111001) begin
      bad++; $display("FAIL timeout_flag: to=%b sc=%0d ctl=%b want to=1 sc=4 ctl=111001", mem_timeout, stall_count, ctl);
    end
    tick();
    tick();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    model_eval();
    total++;
    if (mem_timeout !== 1'b0 || stall_count !== '0 || ctl !== e_ctl) begin
      bad++; $display("FAIL reset_mid_access: to=%b sc=%0d ctl=%b want to=0 sc=0 ctl=%b", mem_timeout, stall_count, ctl, e_ctl);
    end
    mem_req = 1'b0;
    #1;
    total++;
    if (ctl !== 6'd0) begin
      bad++; $display("FAIL reset_state_run: ctl=%b want 000000", ctl);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
      total++;
      if (ctl !== e_ctl || mem_timeout !== m_to ||
          stall_count !== CW'(m_sc) || flush_count !== CW'(m_fc)) begin
        bad++;
        $display("FAIL random c=%0d: ctl=%b to=%b sc=%0d fc=%0d want ctl=%b to=%b sc=%0d fc=%0d",
                 c, ctl, mem_timeout, stall_count, flush_count, e_ctl, m_to, m_sc, m_fc);
      end
      tick();
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_hazard();
    test_mem_access();
    test_branch_in_wait();
    test_branch_hazard();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
